// File: rtl/fsqrt_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fsqrt_ctrl: issue/retire controller around a fixed-latency fsqrt pipeline. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fsqrt_ctrl #(
  parameter int LAT   = 3,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      sq_x,
  input  logic [31:0]      sq_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag
);
  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam int          IW      = $clog2(LAT + 1);
  localparam logic [31:0] DEPTH_U = DEPTH;

  logic [LAT-1:0]   v_q, v_d, spec_q, spec_d;
  logic [TAG_W-1:0] tag_q [LAT];
  logic [TAG_W-1:0] tag_d [LAT];
  logic [31:0]      sval_q [LAT];
  logic [31:0]      sval_d [LAT];
  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];
  logic [TAG_W-1:0] mtag_q [DEPTH];
  logic [TAG_W-1:0] mtag_d [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [IW-1:0]    inflight_q, inflight_d;

  logic        accept, push, pop, is_spec;
  logic [31:0] spec_val, push_y;

  always_comb begin
    is_spec  = 1'b1;
    spec_val = 32'h0;
    if (in_x[30:23] == 8'h00)
      spec_val = {in_x[31], 31'b0};
    else if (in_x[30:23] == 8'hFF && in_x[22:0] != 23'h0)
      spec_val = 32'h7FC0_0000;
    else if (in_x[30:23] == 8'hFF && !in_x[31])
      spec_val = 32'h7F80_0000;
    else if (in_x[31])
      spec_val = 32'h7FC0_0000;
    else
      is_spec = 1'b0;
  end

  // Registered credits only: a same-cycle pop is not counted, so admission is one cycle conservative.
  assign in_ready  = rstn && ((32'(count_q) + 32'(inflight_q)) < DEPTH_U);
  assign accept    = in_valid & in_ready;
  assign sq_x      = accept ? in_x : 32'h0;
  assign push      = v_q[LAT-1];
  assign push_y    = spec_q[LAT-1] ? sval_q[LAT-1] : sq_y;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign out_y     = out_valid ? mem_q[rd_q] : 32'h0;
  assign out_tag   = out_valid ? mtag_q[rd_q] : '0;

  always_comb begin
    v_d       = v_q;
    spec_d    = spec_q;
    tag_d     = tag_q;
    sval_d    = sval_q;
    v_d[0]    = accept;
    spec_d[0] = is_spec;
    tag_d[0]  = in_tag;
    sval_d[0] = spec_val;
    for (int i = 1; i < LAT; i++) begin
      v_d[i]    = v_q[i-1];
      spec_d[i] = spec_q[i-1];
      tag_d[i]  = tag_q[i-1];
      sval_d[i] = sval_q[i-1];
    end
    inflight_d = '0;
    for (int i = 0; i < LAT; i++)
      inflight_d = inflight_d + IW'(v_d[i]);
  end

  always_comb begin
    mem_d  = mem_q;
    mtag_d = mtag_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    if (push) begin
      mem_d[wr_q]  = push_y;
      mtag_d[wr_q] = tag_q[LAT-1];
      wr_d         = wr_q + AW'(1);
    end
    if (pop)
      rd_d = rd_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q        <= '0;
      spec_q     <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_q[i]  <= '0;
        sval_q[i] <= '0;
      end
    end else begin
      v_q        <= v_d;
      spec_q     <= spec_d;
      tag_q      <= tag_d;
      sval_q     <= sval_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  // Storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q  <= mem_d;
    mtag_q <= mtag_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_fsqrt_ctrl.sv
`default_nettype none
// tb_fsqrt_ctrl: directed checks of fsqrt_ctrl with a behavioural fsqrt pipeline.
// A DEPTH=4 instance covers latency/specials/backpressure/reset; a DEPTH=8 one covers streaming.
module tb_fsqrt_ctrl;
  localparam int LAT   = 3;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstn, sel, in_valid, out_ready;
  logic [31:0]      in_x;
  logic [TAG_W-1:0] in_tag;

  logic             ir4, ov4, ir8, ov8;
  logic [31:0]      sx4, sy4, oy4, sx8, sy8, oy8;
  logic [TAG_W-1:0] ot4, ot8;
  logic [31:0]      p4 [LAT];
  logic [31:0]      p8 [LAT];

  logic             ir, ov;
  logic [31:0]      oy;
  logic [TAG_W-1:0] ot;
  assign ir = sel ? ir8 : ir4;
  assign ov = sel ? ov8 : ov4;
  assign oy = sel ? oy8 : oy4;
  assign ot = sel ? ot8 : ot4;

  // Stand-in for the arithmetic: exact roots for the directed operands, a fixed bijection otherwise.
  function automatic logic [31:0] fsq(input logic [31:0] x);
    case (x)
      32'h4080_0000: fsq = 32'h4000_0000;
      32'h4110_0000: fsq = 32'h4040_0000;
      default:       fsq = x ^ 32'h1234_5678;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    p4[0] <= fsq(sx4);
    for (int i = 1; i < LAT; i++) p4[i] <= p4[i-1];
  end
  always_ff @(posedge clk) begin
    p8[0] <= fsq(sx8);
    for (int j = 1; j < LAT; j++) p8[j] <= p8[j-1];
  end
  assign sy4 = p4[LAT-1];
  assign sy8 = p8[LAT-1];

  fsqrt_ctrl #(.LAT(LAT), .DEPTH(4), .TAG_W(TAG_W)) dut4 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid & ~sel), .in_ready(ir4),
    .in_x(in_x), .in_tag(in_tag), .sq_x(sx4), .sq_y(sy4),
    .out_valid(ov4), .out_ready(out_ready & ~sel), .out_y(oy4), .out_tag(ot4));

  fsqrt_ctrl #(.LAT(LAT), .DEPTH(8), .TAG_W(TAG_W)) dut8 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid & sel), .in_ready(ir8),
    .in_x(in_x), .in_tag(in_tag), .sq_x(sx8), .sq_y(sy8),
    .out_valid(ov8), .out_ready(out_ready & sel), .out_y(oy8), .out_tag(ot8));

  int                   checks = 0, errors = 0, acc = 0, pops = 0;
  logic [31:0]          cur_exp;
  logic [TAG_W+31:0]    expq [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Records accepts, checks every pop against the in-order expectation, then advances one cycle.
  task automatic tick();
    if (in_valid && ir) begin
      expq.push_back({in_tag, cur_exp});
      acc++;
    end
    if (ov && out_ready) begin
      pops++;
      if (expq.size() == 0) chk("pop_unexpected", 64'(ov), 64'd0);
      else                  chk("pop_data", 64'({ot, oy}), 64'(expq.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x, input logic [TAG_W-1:0] tg, input logic [31:0] ey);
    int n;
    in_valid = 1'b1;
    in_x     = x;
    in_tag   = tg;
    cur_exp  = ey;
    n        = 0;
    while (!ir && n < 40) begin
      tick();
      n++;
    end
    if (!ir) chk("send_timeout", 64'(ir), 64'd1);
    else     tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] sp_x [7];
    logic [31:0] sp_e [7];
    int a0, p0;
    sp_x = '{32'h0000_0000, 32'h8000_0000, 32'h4110_0000, 32'h0000_0001,
             32'hBF80_0000, 32'h7F80_0000, 32'h7FA0_0000};
    sp_e = '{32'h0000_0000, 32'h8000_0000, 32'h4040_0000, 32'h0000_0000,
             32'h7FC0_0000, 32'h7F80_0000, 32'h7FC0_0000};

    rstn = 1'b0; sel = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_x = 32'h4080_0000; in_tag = 4'd5; cur_exp = 32'h0;
    #3;
    chk("reset_out_valid", 64'(ov), 64'd0);
    chk("reset_out_y", 64'(oy), 64'd0);
    chk("reset_out_tag", 64'(ot), 64'd0);
    chk("reset_sq_x", 64'(sx4), 64'd0);
    in_valid = 1'b0;
    #10 rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ready", 64'(ir), 64'd1);

    // Single op: accepted at edge k, visible after edge k+3.
    out_ready = 1'b1;
    in_valid = 1'b1; in_x = 32'h4080_0000; in_tag = 4'd5; cur_exp = 32'h4000_0000;
    chk("single_ready", 64'(ir), 64'd1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("single_lat_idle", 64'(ov), 64'd0);
      tick();
    end
    chk("single_valid", 64'(ov), 64'd1);
    chk("single_y", 64'(oy), 64'h4000_0000);
    chk("single_tag", 64'(ot), 64'd5);
    tick();
    chk("single_drained", 64'(ov), 64'd0);

    // Specials interleaved with a normal op.
    p0 = pops;
    for (int i = 0; i < 7; i++) send(sp_x[i], 4'(i + 1), sp_e[i]);
    repeat (10) tick();
    chk("specials_count", 64'(pops - p0), 64'd7);
    chk("specials_queue", 64'(expq.size()), 64'd0);

    // Backpressure: in_valid held 8 cycles with the consumer stalled.
    out_ready = 1'b0;
    a0 = acc;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_x = 32'h4200_0000 | 32'(i); in_tag = 4'(8 + i); cur_exp = fsq(in_x);
      tick();
    end
    in_valid = 1'b0;
    chk("bp_accepted", 64'(acc - a0), 64'd4);
    chk("bp_ready_low", 64'(ir), 64'd0);
    chk("bp_full_valid", 64'(ov), 64'd1);

    // Drain the full FIFO while new ops push behind it; pointers wrap repeatedly.
    out_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 12; i++) send(32'h4300_0000 | 32'(i << 4), 4'(i), fsq(32'h4300_0000 | 32'(i << 4)));
    repeat (12) tick();
    chk("wrap_count", 64'(pops - p0), 64'd16);
    chk("wrap_queue", 64'(expq.size()), 64'd0);

    // Reset with two buffered and two in flight.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_x = 32'h4400_0000 | 32'(i); in_tag = 4'(i); cur_exp = fsq(in_x);
      chk("rst_pre_ready", 64'(ir), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("rst_pre_valid", 64'(ov), 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_async_valid", 64'(ov), 64'd0);
    chk("rst_async_y", 64'(oy), 64'd0);
    expq.delete();
    #10 rstn = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("post_rst_idle", 64'(ov), 64'd0);
      tick();
    end
    chk("post_rst_ready", 64'(ir), 64'd1);

    // Streaming through the DEPTH=8 instance: no admission stall expected.
    sel = 1'b1;
    p0 = pops;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_x     = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      in_tag   = 4'(i);
      cur_exp  = fsq(in_x);
      chk("stream_ready", 64'(ir), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    repeat (10) tick();
    chk("stream_count", 64'(pops - p0), 64'd100);
    chk("stream_queue", 64'(expq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
